// File: rtl/gate_pkg.sv
// Shared types and default timing constants for the gate trigger controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gate_pkg;

   // Gate command sequence states
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      OPEN     = 2'd1,
      COOLDOWN = 2'd2
   } gate_state_e;

   // Default cycle counts at a 50 MHz clock
   localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;    // 20 ms
   localparam int DEF_HOLD_CYCLES     = 150_000_000;  // 3 s
   localparam int DEF_COOL_CYCLES     = 25_000_000;   // 500 ms, covers servo close ramp

   // Timer width; must hold the largest count above
   localparam int DEF_CNT_W = 28;

   // Saturation ceiling of the accepted-open counter
   localparam logic [7:0] OPEN_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/input_debouncer.sv
// Synchronizes a raw asynchronous sensor and debounces it into a stable level plus a rise pulse.
// Latency: db follows a stable input change after DEBOUNCE_CYCLES+1 edges; rise is registered with db.
// Backpressure: none; free-running level path, the pulse is one cycle wide.
module input_debouncer
   import gate_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sensor_in,
   output logic db,
   output logic rise
);

   // Last counter value before the level is accepted (counter holds 0..DEBOUNCE_CYCLES-1)
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             s_q, s_d;
   logic             db_q, db_d;
   logic             rise_q, rise_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next-state: two-stage synchronizer, mismatch counter, level acceptance and rise detect
   always_comb begin
      sync1_d = sensor_in;
      s_d     = sync1_q;
      db_d    = db_q;
      cnt_d   = '0;
      if (s_q != db_q) begin
         if (cnt_q == CNT_LAST) begin
            db_d = s_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      rise_d = db_d & ~db_q;
   end

   // State registers; async reset clears synchronizer, level and counter immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         s_q     <= 1'b0;
         db_q    <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         s_q     <= s_d;
         db_q    <= db_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign db   = db_q;
   assign rise = rise_q;

endmodule

// File: rtl/gate_trigger_ctrl.sv
// Turns a debounced presence sensor into a timed servo enable: OPEN for a hold time, then a COOLDOWN lockout.
// Latency: enable rises DEBOUNCE_CYCLES+2 edges after the sensor is first sampled high; force_close acts on the next edge.
// Backpressure: none; triggers arriving in COOLDOWN are dropped so the gate is never reopened mid-close.
module gate_trigger_ctrl
   import gate_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter int COOL_CYCLES     = DEF_COOL_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sensor_in,
   input  logic       force_close,
   output logic       enable,
   output logic       busy,
   output logic [7:0] open_count
);

   // Timer load values: the timer counts down to 0, so N cycles load N-1
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOL_CYCLES - 1);

   logic db_lvl;
   logic db_rise;
   logic trig;

   gate_state_e      state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [7:0]       open_count_q, open_count_d;
   logic             enable_q, enable_d;
   logic             busy_q, busy_d;
   logic             count_inc;

   input_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_input_debouncer (
      .clk       (clk),
      .rst_n     (rst_n),
      .sensor_in (sensor_in),
      .db        (db_lvl),
      .rise      (db_rise)
   );

   // The rise pulse is only ever high together with the accepted level; qualifying on both
   // makes the trigger robust to any future change in how the pulse is generated.
   assign trig = db_rise & db_lvl;

   // Next-state: FSM, shared hold/cool timer, saturating open counter and registered outputs
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      open_count_d = open_count_q;
      count_inc    = 1'b0;
      case (state_q)
         IDLE: begin
            if (trig) begin
               state_d   = OPEN;
               timer_d   = HOLD_LAST;
               count_inc = 1'b1;
            end
         end
         OPEN: begin
            // force_close outranks a same-cycle retrigger; a retrigger outranks expiry
            if (force_close) begin
               state_d = COOLDOWN;
               timer_d = COOL_LAST;
            end else if (trig) begin
               timer_d   = HOLD_LAST;
               count_inc = 1'b1;
            end else if (timer_q == '0) begin
               state_d = COOLDOWN;
               timer_d = COOL_LAST;
            end else begin
               timer_d = timer_q - CNT_W'(1);
            end
         end
         COOLDOWN: begin
            // Triggers and force_close are deliberately ignored while the servo closes
            if (timer_q == '0) begin
               state_d = IDLE;
            end else begin
               timer_d = timer_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase
      if (count_inc && (open_count_q != OPEN_COUNT_MAX)) begin
         open_count_d = open_count_q + 8'd1;
      end
      enable_d = (state_d == OPEN);
      busy_d   = (state_d != IDLE);
   end

   // FSM and output registers; async reset returns to IDLE with everything cleared, even mid-OPEN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         timer_q      <= '0;
         open_count_q <= 8'd0;
         enable_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         open_count_q <= open_count_d;
         enable_q     <= enable_d;
         busy_q       <= busy_d;
      end
   end

   assign enable     = enable_q;
   assign busy       = busy_q;
   assign open_count = open_count_q;

endmodule

// File: tb/tb_gate_trigger_ctrl.sv
// Directed bench for gate_trigger_ctrl with short timing parameters.
// Latency: observes outputs 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_gate_trigger_ctrl;

   localparam int DB_C   = 4;
   localparam int HOLD_C = 10;
   localparam int COOL_C = 6;
   localparam int WIN    = 40;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sensor_in;
   logic       force_close;
   logic       enable;
   logic       busy;
   logic [7:0] open_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string name;
      int    p1_start;
      int    p1_len;
      int    p2_start;
      int    p2_len;
      int    bounce;
      int    fc_edge;
      int    exp_rise;
      int    exp_en;
      int    exp_busy;
      int    exp_cnt;
   } vec_t;

   vec_t vecs[10];

   gate_trigger_ctrl #(
      .DEBOUNCE_CYCLES (DB_C),
      .HOLD_CYCLES     (HOLD_C),
      .COOL_CYCLES     (COOL_C),
      .CNT_W           (28)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sensor_in   (sensor_in),
      .force_close (force_close),
      .enable      (enable),
      .busy        (busy),
      .open_count  (open_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reset with quiet inputs; release 1 unit after an edge so the next edge is edge 0
   task automatic do_reset();
      rst_n       = 1'b0;
      sensor_in   = 1'b0;
      force_close = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   function automatic logic sensor_val(input vec_t v, input int i);
      logic val;
      if (v.bounce != 0) begin
         val = (i < 20) && (((i / 2) % 2) == 0);
      end else begin
         val = ((i >= v.p1_start) && (i < v.p1_start + v.p1_len)) ||
               ((v.p2_len > 0) && (i >= v.p2_start) && (i < v.p2_start + v.p2_len));
      end
      return val;
   endfunction

   task automatic run_vec(input vec_t v);
      int rise;
      int en_n;
      int busy_n;
      rise   = -1;
      en_n   = 0;
      busy_n = 0;
      do_reset();
      for (int i = 0; i < WIN; i++) begin
         sensor_in   = sensor_val(v, i);
         force_close = (i == v.fc_edge);
         @(posedge clk);
         #1;
         if (enable && (rise < 0)) rise = i;
         if (enable) en_n++;
         if (busy) busy_n++;
      end
      force_close = 1'b0;
      check({v.name, ".rise"}, rise, v.exp_rise);
      check({v.name, ".en_len"}, en_n, v.exp_en);
      check({v.name, ".busy_len"}, busy_n, v.exp_busy);
      check({v.name, ".count"}, int'(open_count), v.exp_cnt);
   endtask

   initial begin
      int rise;

      //                 name          p1s p1l p2s p2l bnc fc  rise en busy cnt
      vecs[0] = '{"clean8",     0, 8, -1, 0, 0, -1,  6, 10, 16, 1};
      vecs[1] = '{"min4",       0, 4, -1, 0, 0, -1,  6, 10, 16, 1};
      vecs[2] = '{"short3",     0, 3, -1, 0, 0, -1, -1,  0,  0, 0};
      vecs[3] = '{"bounce",     0, 0, -1, 0, 1, -1, -1,  0,  0, 0};
      vecs[4] = '{"long20",     0, 20, -1, 0, 0, -1, 6, 10, 16, 1};
      vecs[5] = '{"retrig",     0, 4,  8, 8, 0, -1,  6, 18, 24, 2};
      vecs[6] = '{"fc_open",    0, 4,  8, 8, 0,  9,  6,  3,  9, 1};
      vecs[7] = '{"fc_vs_trig", 0, 4,  8, 8, 0, 14,  6,  8, 14, 1};
      vecs[8] = '{"fc_idle",    0, 4,  8, 8, 0,  3,  6, 18, 24, 2};
      vecs[9] = '{"fc_cool",    0, 8, -1, 0, 0, 18,  6, 10, 16, 1};

      // Reset held with the sensor high: outputs stay 0, then normal latency after release
      rst_n       = 1'b0;
      sensor_in   = 1'b1;
      force_close = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.enable", int'(enable), 0);
      check("rst.busy", int'(busy), 0);
      check("rst.count", int'(open_count), 0);
      rst_n = 1'b1;
      rise  = -1;
      for (int i = 0; i < 20; i++) begin
         sensor_in = (i < 8);
         @(posedge clk);
         #1;
         if (enable && (rise < 0)) rise = i;
      end
      check("rst.first_rise", rise, 6);

      // Table of directed scenarios
      for (int k = 0; k < 10; k++) begin
         run_vec(vecs[k]);
      end

      // Async reset on the 5th OPEN cycle clears outputs without a clock edge
      do_reset();
      for (int i = 0; i <= 10; i++) begin
         sensor_in = (i < 8);
         @(posedge clk);
         #1;
      end
      check("midopen.enable_before", int'(enable), 1);
      check("midopen.count_before", int'(open_count), 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("midopen.enable_after", int'(enable), 0);
      check("midopen.busy_after", int'(busy), 0);
      check("midopen.count_after", int'(open_count), 0);
      #1;
      rst_n = 1'b1;

      // Saturation: a debounced rise every 8 cycles keeps retriggering the open
      do_reset();
      for (int i = 0; i < 270 * 8; i++) begin
         sensor_in = ((i % 8) < 4);
         @(posedge clk);
         #1;
         if (i == 100 * 8 - 1) check("sat.count_100", int'(open_count), 100);
      end
      check("sat.count_final", int'(open_count), 255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
